// File: rtl/odd_value_picker.sv
// rtl/odd_value_picker.sv - collects COUNT distinct odd 4-bit values from an LFSR stream
// Readable slot array, bounded by a try budget that flags failure instead of hanging.
module odd_value_picker #(
  parameter int COUNT     = 4,
  parameter int MAX_TRIES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] random_in,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] count_out,
  input  logic [2:0] rd_idx,
  output logic [3:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  localparam logic [3:0] COUNT_L     = 4'(COUNT);
  localparam logic [7:0] MAX_TRIES_L = 8'(MAX_TRIES);

  state_t     state;
  state_t     state_next;
  logic [7:0] mask;
  logic [3:0] slots [8];
  logic [3:0] count;
  logic [7:0] tries;
  logic       accept;
  logic       fill_hit;
  logic       tries_hit;

  // The mask is indexed by the upper bits since only odd values are ever stored.
  assign accept    = random_in[0] && !mask[random_in[3:1]];
  assign fill_hit  = accept && ((count + 4'd1) == COUNT_L);
  assign tries_hit = (tries + 8'd1) == MAX_TRIES_L;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (fill_hit)       state_next = ST_DONE;
        else if (tries_hit) state_next = ST_FAIL;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask  <= '0;
      count <= '0;
      tries <= '0;
      for (int i = 0; i < 8; i++) slots[i] <= '0;
    end else if (state == ST_COLLECT) begin
      tries <= tries + 8'd1;
      if (accept) begin
        slots[count[2:0]]     <= random_in;
        mask[random_in[3:1]]  <= 1'b1;
        count                 <= count + 4'd1;
      end
    end else if (start) begin
      mask  <= '0;
      count <= '0;
      tries <= '0;
      for (int i = 0; i < 8; i++) slots[i] <= '0;
    end
  end

  always_comb begin
    busy      = (state == ST_COLLECT);
    done      = (state == ST_DONE);
    error     = (state == ST_FAIL);
    count_out = count;
    rd_data   = 4'd0;
    if (({1'b0, rd_idx} < count) && (32'(rd_idx) < COUNT)) rd_data = slots[rd_idx];
  end

endmodule
